// File: rtl/mul_div_pkg.sv
// Shared encodings and constants for the MIPS multiply/divide unit.
package mul_div_pkg;

  localparam int          DIV_ITERS_DEFAULT = 32;
  localparam logic [31:0] DIV0_QUOT         = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIV_RUN = 2'b01,
    DONE    = 2'b10
  } state_t;

  // Magnitude of a 32-bit operand; only negates when the op is signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage request / HI-LO write-back bundle for mul_div_unit.
interface mul_div_unit_if;
  import mul_div_pkg::*;

  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_result;
  logic [31:0] lo_result;
  logic [1:0]  hilo_write;

  modport master (
    output op_valid, op_type, src_a, src_b, flush,
    input  busy, done, hi_result, lo_result, hilo_write
  );

  modport slave (
    input  op_valid, op_type, src_a, src_b, flush,
    output busy, done, hi_result, lo_result, hilo_write
  );

endinterface

// File: rtl/mul_div_unit_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step
  import mul_div_pkg::*;
(
  input  logic [31:0] rem,
  input  logic [31:0] dvd,
  input  logic [31:0] dvs,
  output logic [31:0] rem_n,
  output logic        q
);

  // Shifted remainder can reach 33 bits when the divisor exceeds 2^31.
  logic [32:0] shl;
  logic [33:0] diff;

  assign shl   = {rem, dvd[31]};
  assign diff  = {1'b0, shl} - {2'b00, dvs};
  assign q     = ~diff[33];
  assign rem_n = q ? diff[31:0] : shl[31:0];

endmodule

// File: rtl/mul_div_unit.sv
// MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers; iterative restoring divide.
// Build option: define MUL_DIV_EARLY_TERM_EN to finish |a| < |b| divides in one cycle.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int            CW   = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   rem, dvd, dvs, hi_q, lo_q;
  logic          neg_q, neg_r;

  logic          is_div, sgn, b_zero, early, accept, div_start, last;
  logic [31:0]   mag_a, mag_b, rem_n, q_raw, q_fin, r_fin;
  logic          qb;
  logic [63:0]   ae, be, prod;
  logic          busy_c, done_c;

  assign is_div = bus.op_type[1];
  assign sgn    = ~bus.op_type[0];
  assign b_zero = (bus.src_b == 32'd0);
  assign mag_a  = mag32(bus.src_a, sgn & is_div);
  assign mag_b  = mag32(bus.src_b, sgn & is_div);

`ifdef MUL_DIV_EARLY_TERM_EN
  assign early = (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  // DONE accepts like IDLE so results can issue back-to-back.
  assign accept    = (state != DIV_RUN) && bus.op_valid && !bus.flush;
  assign div_start = is_div && !b_zero && !early;
  assign last      = (state == DIV_RUN) && (cnt == LAST);

  // Sign-extend for MULT, zero-extend for MULTU; low 64 bits are the product.
  assign ae   = {{32{sgn & bus.src_a[31]}}, bus.src_a};
  assign be   = {{32{sgn & bus.src_b[31]}}, bus.src_b};
  assign prod = ae * be;

  div_step u_step (
    .rem   (rem),
    .dvd   (dvd),
    .dvs   (dvs),
    .rem_n (rem_n),
    .q     (qb)
  );

  // Quotient bits shift into the dividend register as dividend bits shift out.
  assign q_raw = {dvd[30:0], qb};
  assign q_fin = neg_q ? -q_raw : q_raw;
  assign r_fin = neg_r ? -rem_n : rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (!bus.op_valid)  state_n = IDLE;
          else if (is_div && div_start) state_n = DIV_RUN;
          else                state_n = DONE;
        end
        DIV_RUN: if (last) state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_c = (state == DIV_RUN);
    done_c = (state == DONE) && !bus.flush;
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.hilo_write = {done_c, done_c};
  assign bus.hi_result  = hi_q;
  assign bus.lo_result  = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (!is_div) begin
        hi_q <= prod[63:32];
        lo_q <= prod[31:0];
      end else if (b_zero) begin
        hi_q <= bus.src_a;
        lo_q <= DIV0_QUOT;
      end else if (early) begin
        hi_q <= bus.src_a;
        lo_q <= '0;
      end else begin
        rem   <= '0;
        dvd   <= mag_a;
        dvs   <= mag_b;
        neg_q <= sgn & (bus.src_a[31] ^ bus.src_b[31]);
        neg_r <= sgn & bus.src_a[31];
      end
    end else if (state == DIV_RUN) begin
      rem <= rem_n;
      dvd <= q_raw;
      cnt <= cnt + 1'b1;
      if (last) begin
        hi_q <= r_fin;
        lo_q <= q_fin;
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multiply/divide execution unit sitting directly upstream of the HI/LO register pair in the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and computes the 64-bit product, or the quotient and remainder.
- Produces a one-cycle write strobe with HI/LO data to load the HI/LO registers.
- Division is iterative (radix-2 restoring), so the unit exposes busy for the pipeline stall logic.

Parameters:
- DIV_ITERS, 32, number of restoring-division iterations (equals operand width; not intended to be changed).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- op_valid  input  1  operation request; sampled only when busy=0.
- op_type  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  input  32  rs operand (multiplicand / dividend).
- src_b  input  32  rt operand (multiplier / divisor).
- flush  input  1  pipeline flush; aborts any in-flight operation.
- busy  output  1  high while a division is iterating; the EX stage stalls.
- done  output  1  one-cycle pulse when a result is valid.
- hi_result  output  32  product[63:32] or remainder.
- lo_result  output  32  product[31:0] or quotient.
- hilo_write  output  2  bit1 = write HI, bit0 = write LO; equals {done,done}.

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, hilo_write=0, hi_result=0, lo_result=0, internal accumulators 0.
- States:
  - IDLE: a request is accepted when op_valid=1 and flush=0.
    - MULT/MULTU go to DONE.
    - DIV/DIVU with src_b≠0 go to DIV_RUN.
    - DIV/DIVU with src_b=0 go to DONE.
  - DIV_RUN: counter runs 0..DIV_ITERS-1, one restoring step per cycle on magnitudes. After the last iteration → DONE.
  - DONE: done=1 and hilo_write=2'b11 for exactly one cycle, with results registered. A new op_valid accepted in DONE is handled exactly as from IDLE (back-to-back issue allowed); otherwise → IDLE.
- busy = (state==DIV_RUN).
  - op_valid while busy is ignored and not queued; the issuer holds the request until busy=0.
- Latency, measured from the accepting edge to the edge that asserts done:
  - multiply: 1 cycle;
  - divide: DIV_ITERS+1 = 33 cycles;
  - divide-by-zero: 1 cycle.
- Operands are latched at accept; later changes to src_a/src_b have no effect.
- Multiply: signed (MULT) or unsigned (MULTU) 32x32 → 64-bit product. Example: MULT of 0xFFFFFFFF by 2 gives hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Divide:
  - DIVU: unsigned quotient and remainder.
  - DIV: operate on magnitudes. Quotient is negated when sign(a)≠sign(b); remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- Divide by zero: lo=0xFFFFFFFF, hi=src_a. No trap is raised.
- flush: takes priority over everything.
  - Synchronously forces state=IDLE, suppresses done/hilo_write that cycle, and discards any partial result.
  - flush coincident with op_valid: the request is not accepted.
- hi_result/lo_result hold their last values outside DONE; they are meaningful only while done=1.

Optional Feature:
- Macro MUL_DIV_EARLY_TERM_EN.
- Defined: a DIV/DIVU with |src_a| < |src_b| (unsigned compare of magnitudes) and src_b≠0 goes IDLE→DONE in 1 cycle, with lo=0 and hi=src_a (sign preserved).
- Undefined: every nonzero-divisor divide takes the full 33 cycles. Results are identical in both builds; only latency differs.

Decomposition:
- Package mul_div_pkg holds:
  - op_type encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state encoding (IDLE, DIV_RUN, DONE);
  - the DIV_ITERS default;
  - the divide-by-zero quotient constant 32'hFFFFFFFF.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, dividend shift register, divisor magnitude.
  - Outputs: next remainder and quotient bit.
  - Instantiated once and reused each cycle.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=3 → done 1 cycle after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA; hilo_write=2'b11 for one cycle.
- DIVU src_a=100, src_b=7 → busy high 32 cycles; done at cycle 33; lo=14, hi=2.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV 0x80000000 by -1 → lo=0x80000000, hi=0.
- DIVU src_b=0, src_a=0x1234 → done after 1 cycle; lo=0xFFFFFFFF, hi=0x1234; busy never asserted.
- Start DIV, assert flush at iteration 10 → no done pulse and busy drops next cycle. A new MULTU 5×6 issued afterwards completes with hi=0, lo=30.
- Assert rst mid-DIV_RUN (asynchronously, between edges) → busy/done/hilo_write drop immediately to 0. After release, a new op completes normally. With MUL_DIV_EARLY_TERM_EN, DIVU 3/10 → done after 1 cycle, lo=0, hi=3.
